// File: rtl/noc_pkt_defs.sv
// Packet field map shared by the NoC injectors and the ejector sink.
// One 32-bit flit carries the whole packet.
package noc_pkt_defs;

  localparam int PKT_W    = 32;
  localparam int DIM      = 4;

  localparam int XDST_MSB = 31;
  localparam int XDST_LSB = 28;
  localparam int YDST_MSB = 27;
  localparam int YDST_LSB = 24;
  localparam int XSRC_MSB = 23;
  localparam int XSRC_LSB = 20;
  localparam int YSRC_MSB = 19;
  localparam int YSRC_LSB = 16;
  localparam int PID_MSB  = 15;
  localparam int PID_LSB  = 6;
  localparam int SRCM_MSB = 5;
  localparam int SRCM_LSB = 0;

  localparam int PID_W    = PID_MSB - PID_LSB + 1;

  typedef enum logic {
    ACC_IDLE,
    ACC_GRANT
  } acc_state_e;

  function automatic logic [2*DIM-1:0] pkt_dst(
    input logic [PKT_W-1:0] p
  );
    return {p[XDST_MSB:XDST_LSB], p[YDST_MSB:YDST_LSB]};
  endfunction

  function automatic logic [PID_W-1:0] pkt_id(
    input logic [PKT_W-1:0] p
  );
    return p[PID_MSB:PID_LSB];
  endfunction

endpackage

// File: rtl/ejector_fifo.sv
// Synchronous FIFO buffering captured packets in the ejector sink.
// Read data is the head entry, valid whenever the FIFO is non-empty.
module ejector_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_data,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  // storage array, no reset needed: occupancy is tracked by the pointers
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // pointers wrap naturally; count moves only on a lone push or pop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (i_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/ejector_sink.sv
// Local-port packet sink: grants router requests into a FIFO, drains
// at a programmable gap, checks destination and keeps statistics.
module ejector_sink
  import noc_pkt_defs::*;
#(
  parameter logic [5:0] ModuleID  = 6'b000_000,
  parameter logic [3:0] MY_X      = 4'b0_000,
  parameter logic [3:0] MY_Y      = 4'b0_000,
  parameter int         dataWidth = 32,
  parameter int         DEPTH     = 4,
  parameter int         DRAIN_GAP = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ReqUpStr,
  input  logic [dataWidth-1:0] PacketIn,
  output logic                 GntUpStr,
  output logic                 UpStrFull,
  output logic                 PktValid,
  output logic [dataWidth-1:0] PktData,
  output logic [5:0]           PktSrcOut,
  output logic [31:0]          RxCount,
  output logic [15:0]          DstErrCount,
  output logic [9:0]           LastID
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam int GW = (DRAIN_GAP > 0) ? $clog2(DRAIN_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LD = GW'(DRAIN_GAP);

  acc_state_e r_state;
  acc_state_e w_next;
  logic       w_push;
  logic       r_gnt;

  logic [dataWidth-1:0] w_head;
  logic                 w_fifo_full;
  logic                 w_empty;
  logic [CW-1:0]        w_count;
  logic                 w_full;

  logic [GW-1:0]        r_gap;
  logic                 w_pop;
  logic                 r_pop_q;
  logic [dataWidth-1:0] r_pop_data;

  logic                 r_valid;
  logic [dataWidth-1:0] r_data;
  logic [31:0]          r_rx;
  logic [15:0]          r_err;
  logic [PID_W-1:0]     r_last;

  assign w_full = (w_count == FULL_CNT);

  ejector_fifo #(
    .DW    (dataWidth),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (PacketIn),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // accept FSM: capture in IDLE, then one deaf GRANT cycle
  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    unique case (r_state)
      ACC_IDLE: begin
        if (ReqUpStr && !w_full) begin
          w_push = 1'b1;
          w_next = ACC_GRANT;
        end
      end
      ACC_GRANT: begin
        w_next = ACC_IDLE;
      end
    endcase
  end

  // state register and registered one-cycle grant pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ACC_IDLE;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gnt   <= w_push;
    end
  end

  assign w_pop = !w_empty && (r_gap == '0);

  // drain timer: reload after each pop, count down to zero otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gap <= '0;
    end else if (w_pop) begin
      r_gap <= GAP_LD;
    end else if (r_gap != '0) begin
      r_gap <= r_gap - GW'(1);
    end
  end

  // pop stage: hold the popped word for the strobe cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pop_q    <= 1'b0;
      r_pop_data <= '0;
    end else begin
      r_pop_q <= w_pop;
      if (w_pop) begin
        r_pop_data <= w_head;
      end
    end
  end

  // strobe stage: publish packet and update saturating statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_rx    <= '0;
      r_err   <= '0;
      r_last  <= '0;
    end else begin
      r_valid <= r_pop_q;
      if (r_pop_q) begin
        r_data <= r_pop_data;
        r_last <= pkt_id(r_pop_data);
        if (r_rx != '1) begin
          r_rx <= r_rx + 32'd1;
        end
        if (pkt_dst(r_pop_data) != {MY_X, MY_Y} && r_err != '1) begin
          r_err <= r_err + 16'd1;
        end
      end
    end
  end

  // by construction the FIFO is never overrun or underrun
  a_no_push_full: assert property (
    @(posedge clk) disable iff (reset) !(w_push && w_fifo_full)
  ) else $error("ejector_sink: push into full FIFO");

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (reset) !(w_pop && w_empty)
  ) else $error("ejector_sink: pop from empty FIFO");

  assign GntUpStr    = r_gnt;
  assign UpStrFull   = w_full;
  assign PktValid    = r_valid;
  assign PktData     = r_data;
  assign PktSrcOut   = ModuleID;
  assign RxCount     = r_rx;
  assign DstErrCount = r_err;
  assign LastID      = r_last;

endmodule

// File: tb/tb_ejector_sink.sv
// Scoreboard bench for ejector_sink: dut0 drains every cycle,
// dut1 drains with a 15-cycle gap so its FIFO can fill.
module tb_ejector_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] pin0, pin1;
  logic        gnt0, gnt1, full0, full1, pv0, pv1;
  logic [31:0] pd0, pd1, rx0, rx1;
  logic [5:0]  src0, src1;
  logic [15:0] err0, err1;
  logic [9:0]  lid0, lid1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int m_rx0 = 0, m_err0 = 0, m_rx1 = 0, m_err1 = 0;
  int gc0 = 0, gc1 = 0, pvc0 = 0, pvc1 = 0;

  bit t3_on = 0;
  bit t3_pf = 0;
  int t3_viol = 0, t3_rise = 0, t3_rise_gnt = 0;
  int t3_fall = -1, t3_resume = -1;

  always #5 clk = ~clk;

  ejector_sink #(
    .ModuleID(6'h08), .MY_X(4'b1001), .MY_Y(4'b0000),
    .dataWidth(32), .DEPTH(4), .DRAIN_GAP(0)
  ) dut0 (
    .clk(clk), .reset(reset), .ReqUpStr(req0), .PacketIn(pin0),
    .GntUpStr(gnt0), .UpStrFull(full0), .PktValid(pv0),
    .PktData(pd0), .PktSrcOut(src0), .RxCount(rx0),
    .DstErrCount(err0), .LastID(lid0)
  );

  ejector_sink #(
    .ModuleID(6'h11), .MY_X(4'b1001), .MY_Y(4'b0000),
    .dataWidth(32), .DEPTH(4), .DRAIN_GAP(15)
  ) dut1 (
    .clk(clk), .reset(reset), .ReqUpStr(req1), .PacketIn(pin1),
    .GntUpStr(gnt1), .UpStrFull(full1), .PktValid(pv1),
    .PktData(pd1), .PktSrcOut(src1), .RxCount(rx1),
    .DstErrCount(err1), .LastID(lid1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: grant counts, scoreboard pops, full-window tracking
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!reset) begin
      if (gnt0) gc0++;
      if (gnt1) gc1++;
      if (pv0) begin
        e = (q0.size() != 0) ? q0.pop_front() : 32'hDEAD_BEEF;
        m_rx0++;
        if (e[31:24] != 8'h90) m_err0++;
        check("d0_data", pd0, e);
        check("d0_lastid", 32'(lid0), 32'(e[15:6]));
        check("d0_rx", rx0, m_rx0);
        check("d0_err", 32'(err0), m_err0);
        pvc0++;
      end
      if (pv1) begin
        e = (q1.size() != 0) ? q1.pop_front() : 32'hDEAD_BEEF;
        m_rx1++;
        if (e[31:24] != 8'h90) m_err1++;
        check("d1_data", pd1, e);
        check("d1_lastid", 32'(lid1), 32'(e[15:6]));
        check("d1_rx", rx1, m_rx1);
        check("d1_err", 32'(err1), m_err1);
        pvc1++;
      end
      if (t3_on) begin
        if (gnt1 && t3_pf) t3_viol++;
        if (full1 && !t3_pf) begin
          t3_rise++;
          if (gnt1) t3_rise_gnt++;
        end
        if (!full1 && t3_pf && t3_fall < 0) t3_fall = cyc;
        if (gnt1 && t3_fall >= 0 && t3_resume < 0) t3_resume = cyc;
        t3_pf = full1;
      end
    end
  end

  task automatic send(input int d, input logic [31:0] w, output int t0);
    bit ok;
    ok = 0;
    t0 = cyc;
    if (d == 0) begin req0 = 1'b1; pin0 = w; end
    else        begin req1 = 1'b1; pin1 = w; end
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if ((d == 0 && gnt0) || (d == 1 && gnt1)) ok = 1;
    end
    check("gnt_seen", 32'(ok), 1);
    if (ok) begin
      if (d == 0) q0.push_back(w);
      else        q1.push_back(w);
    end
    @(posedge clk);
    #1;
    if (d == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic drain(input int d);
    for (int n = 0; n < 400; n++) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) break;
      @(negedge clk);
    end
    check("drain", 32'(d == 0 ? q0.size() : q1.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, lat, g0, p0;
    logic [31:0] w;
    bit seen;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    pin0 = '0;   pin1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt0), 0);
    check("rst_full", 32'(full0), 0);
    check("rst_pv", 32'(pv0), 0);
    check("rst_pd", pd0, 0);
    check("rst_rx", rx0, 0);
    check("rst_err", 32'(err0), 0);
    check("rst_lid", 32'(lid0), 0);
    check("rst_src", 32'(src0), 32'h08);
    check("rst_src1", 32'(src1), 32'h11);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // T1: single matching packet, latency and stats
    g0 = gc0;
    send(0, 32'h9000_0040, t0);
    lat = -1;
    for (int n = 0; n < 10 && lat < 0; n++) begin
      @(negedge clk);
      if (pv0) lat = cyc - t0;
    end
    check("t1_latency", lat, 3);
    drain(0);
    check("t1_gnt", gc0 - g0, 1);
    check("t1_rx", rx0, 1);
    check("t1_err", 32'(err0), 0);
    check("t1_lid", 32'(lid0), 1);

    // T2: Req stays up through the deaf GRANT cycle -> one capture
    g0 = gc0;
    send(0, 32'h9000_0080, t0);
    drain(0);
    repeat (5) @(negedge clk);
    check("t2_gnt", gc0 - g0, 1);
    check("t2_rx", rx0, 2);

    // T4: wrong destination
    send(0, 32'h2000_00C0, t0);
    drain(0);
    check("t4_err", 32'(err0), 1);
    check("t4_rx", rx0, 3);
    check("t4_pd", pd0, 32'h2000_00C0);

    // T3: back-to-back into the slow-draining sink
    t3_pf = full1;
    t3_on = 1;
    for (int i = 1; i <= 8; i++) begin
      w = {8'h90, 8'h10, 10'(i + 16), 6'h01};
      send(1, w, t0);
    end
    drain(1);
    t3_on = 0;
    check("t3_gnt_while_full", t3_viol, 0);
    check("t3_full_seen", 32'(t3_rise != 0), 1);
    check("t3_full_on_gnt", t3_rise_gnt, t3_rise);
    check("t3_resume", t3_resume - t3_fall, 1);
    check("t3_rx", rx1, 8);

    // T5: reset during GRANT with two packets queued
    repeat (20) @(negedge clk);
    send(1, 32'h9000_1000, t0);
    send(1, 32'h9000_1040, t0);
    req1 = 1'b1;
    pin1 = 32'h9000_1080;
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (gnt1) seen = 1;
    end
    check("t5_gnt_before", 32'(seen), 1);
    #1;
    reset = 1'b1;
    #1;
    check("t5_gnt", 32'(gnt1), 0);
    check("t5_full", 32'(full1), 0);
    check("t5_rx", rx1, 0);
    check("t5_err", 32'(err1), 0);
    check("t5_lid", 32'(lid1), 0);
    check("t5_pv", 32'(pv1), 0);
    q0.delete();
    q1.delete();
    m_rx0 = 0; m_err0 = 0; m_rx1 = 0; m_err1 = 0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    p0 = pvc1;
    repeat (40) @(negedge clk);
    check("t5_no_pv", pvc1 - p0, 0);

    // T6: long injector-style stream
    for (int i = 1; i <= 1022; i++) begin
      w = {8'h90, 8'h10, 10'(i), 6'h08};
      send(0, w, t0);
    end
    drain(0);
    check("t6_rx", rx0, 1022);
    check("t6_lid", 32'(lid0), 1022);
    check("t6_err", 32'(err0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
